note_lane_engine: RTL and testbench

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

---
 rtl/note_lane_engine.sv | 184 ++++++++++++++++++
 tb/tb_note_lane_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/note_lane_engine.sv
// Falling-note playfield engine: LANES columns of SLOTS note slots that spawn from an
// external sequence ROM, descend one pixel per advance tick and retire at Y_MAX.
module note_lane_engine #(
    parameter  int LANES   = 3,
    parameter  int SLOTS   = 5,
    parameter  int POS_W   = 10,
    parameter  int Y_MAX   = 490,
    parameter  int SEQ_LEN = 23,
    parameter  int GAP_W   = 6,
    localparam int AW      = (SEQ_LEN <= 1) ? 1 : $clog2(SEQ_LEN),
    localparam int NS      = LANES * SLOTS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic [LANES-1:0]         note_bits,
    output logic [AW-1:0]            note_addr,
    output logic [NS*POS_W-1:0]      pos_flat,
    output logic [NS-1:0]            active_flat,
    output logic [1:0]               state,
    output logic [LANES-1:0]         exit_pulse,
    output logic [LANES-1:0]         overflow_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] YM       = POS_W'(Y_MAX);
    localparam logic [AW-1:0]    LAST_ADR = AW'(SEQ_LEN - 1);

    state_t                     state_q, state_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [NS-1:0][POS_W-1:0]   pos_q, pos_d;
    logic [NS-1:0]              act_q, act_d;
    logic [LANES-1:0]           exit_q, exit_d;
    logic [LANES-1:0]           ovf_q, ovf_d;

    // Result of one descent step applied to the current slot contents.
    logic [NS-1:0][POS_W-1:0]   adv_pos;
    logic [NS-1:0]              adv_act;
    logic [LANES-1:0]           adv_exit;

    logic [NS-1:0]              spawn_mask;
    logic [LANES-1:0]           ovf_lane;

    always_comb begin
        adv_pos  = pos_q;
        adv_act  = act_q;
        adv_exit = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (act_q[k*SLOTS+s]) begin
                    if (pos_q[k*SLOTS+s] == YM) begin
                        adv_act[k*SLOTS+s] = 1'b0;
                        adv_pos[k*SLOTS+s] = '0;
                        adv_exit[k]        = 1'b1;
                    end else begin
                        adv_pos[k*SLOTS+s] = pos_q[k*SLOTS+s] + 1'b1;
                    end
                end
            end
        end
    end

    // Free-slot search uses the start-of-cycle active bits, so a slot retiring
    // this cycle is never handed to a note spawning in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SLOTS-1:0] inact;
            logic [SLOTS-1:0] free_oh;
            assign inact   = ~act_q[gi*SLOTS +: SLOTS];
            assign free_oh = inact & (~inact + 1'b1);
            assign spawn_mask[gi*SLOTS +: SLOTS] = note_bits[gi] ? free_oh : '0;
            assign ovf_lane[gi] = note_bits[gi] & ~(|inact);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        pos_d   = pos_q;
        act_d   = act_q;
        exit_d  = '0;
        ovf_d   = '0;
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            gap_d   = '0;
            pos_d   = '0;
            act_d   = '0;
        end else if (!pause) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_PLAY;
                        addr_d  = '0;
                        gap_d   = '0;
                        pos_d   = '0;
                        act_d   = '0;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        pos_d  = adv_pos;
                        act_d  = adv_act;
                        exit_d = adv_exit;
                        gap_d  = gap_q + 1'b1;
                        if (gap_q == '0) begin
                            for (int i = 0; i < NS; i++) begin
                                if (spawn_mask[i]) begin
                                    act_d[i] = 1'b1;
                                    pos_d[i] = '0;
                                end
                            end
                            ovf_d = ovf_lane;
                            if (addr_q == LAST_ADR) begin
                                state_d = S_DRAIN;
                            end else begin
                                addr_d = addr_q + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (tick) begin
                        pos_d  = adv_pos;
                        act_d  = adv_act;
                        exit_d = adv_exit;
                    end
                    if (act_q == '0) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    pos_d = '0;
                    act_d = '0;
                    if (start) begin
                        state_d = S_PLAY;
                        addr_d  = '0;
                        gap_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            gap_q   <= '0;
            pos_q   <= '0;
            act_q   <= '0;
            exit_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            pos_q   <= pos_d;
            act_q   <= act_d;
            exit_q  <= exit_d;
            ovf_q   <= ovf_d;
        end
    end

    assign note_addr      = addr_q;
    assign pos_flat       = pos_q;
    assign active_flat    = act_q;
    assign state          = state_q;
    assign exit_pulse     = exit_q;
    assign overflow_pulse = ovf_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed bench: a default-parameter engine plus a small one whose Y_MAX+1 aligns with
// the spawn interval, so retire-and-spawn collisions and the drain/done path are reachable.
module tb_note_lane_engine;

    logic clk = 1'b0;
    logic reset, tick, stop, pause, start_d, start_s;
    logic [2:0] nb_d, nb_s;

    logic [4:0]   addr_d;
    logic [149:0] posf_d;
    logic [14:0]  act_d;
    logic [1:0]   st_d;
    logic [2:0]   exit_d, ovf_d;

    logic [2:0]   addr_s;
    logic [59:0]  posf_s;
    logic [11:0]  act_s;
    logic [1:0]   st_s;
    logic [2:0]   exit_s, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_lane_engine u_dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start_d), .stop(stop), .pause(pause),
        .note_bits(nb_d), .note_addr(addr_d), .pos_flat(posf_d), .active_flat(act_d),
        .state(st_d), .exit_pulse(exit_d), .overflow_pulse(ovf_d)
    );

    note_lane_engine #(
        .LANES(3), .SLOTS(4), .POS_W(5), .Y_MAX(15), .SEQ_LEN(6), .GAP_W(2)
    ) u_small (
        .clk(clk), .reset(reset), .tick(tick), .start(start_s), .stop(stop), .pause(pause),
        .note_bits(nb_s), .note_addr(addr_s), .pos_flat(posf_s), .active_flat(act_s),
        .state(st_s), .exit_pulse(exit_s), .overflow_pulse(ovf_s)
    );

    // Small-engine sequence ROM: lane0 notes at entries 0 and 4 only.
    assign nb_s = (addr_s == 3'd0 || addr_s == 3'd4) ? 3'b001 : 3'b000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] dpos(input int k, input int s);
        return posf_d[(k*5+s)*10 +: 10];
    endfunction

    function automatic logic [4:0] spos(input int k, input int s);
        return posf_s[(k*4+s)*5 +: 5];
    endfunction

    initial begin
        int first_ovf;
        logic [2:0] first_val;
        int n_ovf;

        reset = 1'b1; tick = 1'b1; stop = 1'b0; pause = 1'b0;
        start_d = 1'b0; start_s = 1'b0; nb_d = 3'b001;
        step(); step();
        reset = 1'b0;
        chk("rst_state", st_d, 0);
        chk("rst_active", act_d, 0);
        chk("rst_addr", addr_d, 0);
        chk("rst_pos", posf_d, 0);
        chk("rst_pulses", {exit_d, ovf_d}, 0);

        // Small engine: retire at Y_MAX colliding with a spawn, then drain and done.
        start_s = 1'b1; step(); start_s = 1'b0;
        chk("s_play", st_s, 1);
        for (int t = 0; t <= 33; t++) begin
            step();
            if (t == 0) begin
                chk("s_t0_act", act_s, 12'h001);
                chk("s_t0_addr", addr_s, 1);
            end
            if (t == 15) chk("s_t15_pos", spos(0, 0), 15);
            if (t == 16) begin
                chk("s_t16_exit", exit_s, 3'b001);
                chk("s_t16_act", act_s, 12'h002);
                chk("s_t16_pos1", spos(0, 1), 0);
                chk("s_t16_ovf", ovf_s, 0);
                chk("s_t16_addr", addr_s, 5);
            end
            if (t == 20) begin
                chk("s_t20_drain", st_s, 2);
                chk("s_t20_addr", addr_s, 5);
            end
            if (t == 31) chk("s_t31_pos1", spos(0, 1), 15);
            if (t == 32) begin
                chk("s_t32_exit", exit_s, 3'b001);
                chk("s_t32_act", act_s, 0);
                chk("s_t32_state", st_s, 2);
            end
            if (t == 33) chk("s_t33_done", st_s, 3);
        end
        start_s = 1'b1; step(); start_s = 1'b0;
        chk("s_restart_state", st_s, 1);
        chk("s_restart_addr", addr_s, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("s_stop_state", st_s, 0);

        // Default engine: single-lane note travels to Y_MAX and exits.
        start_d = 1'b1; step(); start_d = 1'b0;
        chk("d_play", st_d, 1);
        chk("d_play_act", act_d, 0);
        step();
        chk("d_t0_act", act_d, 15'h0001);
        chk("d_t0_pos", dpos(0, 0), 0);
        chk("d_t0_addr", addr_d, 1);
        first_ovf = -1; first_val = '0; n_ovf = 0;
        for (int t = 1; t <= 490; t++) begin
            step();
            if (ovf_d != 3'b000) begin
                n_ovf++;
                if (first_ovf < 0) begin
                    first_ovf = t;
                    first_val = ovf_d;
                end
            end
        end
        chk("d_ovf_first_tick", first_ovf, 320);
        chk("d_ovf_first_val", first_val, 3'b001);
        chk("d_ovf_count", n_ovf, 3);
        chk("d_t490_pos", dpos(0, 0), 490);
        chk("d_t490_addr", addr_d, 8);
        chk("d_t490_act", act_d, 15'h001F);
        step();
        chk("d_t491_exit", exit_d, 3'b001);
        chk("d_t491_act", act_d, 15'h001E);
        chk("d_t491_pos", dpos(0, 0), 0);

        // Pause freezes everything for 100 cycles while tick keeps running.
        pause = 1'b1;
        repeat (100) step();
        chk("p_pos1", dpos(0, 1), 427);
        chk("p_addr", addr_d, 8);
        chk("p_state", st_d, 1);
        chk("p_act", act_d, 15'h001E);
        chk("p_pulses", {exit_d, ovf_d}, 0);
        pause = 1'b0; tick = 1'b0;
        step();
        chk("notick_pos1", dpos(0, 1), 427);
        tick = 1'b1;
        step();
        chk("resume_pos1", dpos(0, 1), 428);
        chk("resume_pos4", dpos(0, 4), 236);

        // All lanes: sixth spawn per lane overflows.
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop1_act", act_d, 0);
        chk("stop1_addr", addr_d, 0);
        nb_d = 3'b111;
        start_d = 1'b1; step(); start_d = 1'b0;
        for (int t = 0; t <= 320; t++) begin
            step();
            if (t == 320) begin
                chk("b_t320_ovf", ovf_d, 3'b111);
                chk("b_t320_act", act_d, 15'h7FFF);
            end
        end
        step();
        chk("b_t321_ovf", ovf_d, 0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop2_act", act_d, 0);
        chk("stop2_state", st_d, 0);
        chk("stop2_exit", exit_d, 0);
        chk("stop2_pos", posf_d, 0);

        // Seven active slots, then reset mid-play.
        nb_d = 3'b111;
        start_d = 1'b1; step(); start_d = 1'b0;
        step();
        nb_d = 3'b011;
        repeat (128) step();
        chk("c_act7", act_d, 15'h04E7);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_act", act_d, 0);
        chk("rst2_state", st_d, 0);
        chk("rst2_exit", exit_d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
